// File: rtl/rtc_sched_pkg.sv
// Shared widths, timestamp/entry payloads and FSM encoding for the RTC trigger scheduler.
// RTC_SCHED_LATE_DROP_EN adds a per-entry late flag to the queued payload.
package rtc_sched_pkg;

    localparam int unsigned SEC_W  = 32;
    localparam int unsigned NSEC_W = 30;

    typedef struct packed {
        logic [SEC_W-1:0]  sec;
        logic [NSEC_W-1:0] nsec;
    } rtc_ts_t;

`ifdef RTC_SCHED_LATE_DROP_EN
    typedef struct packed {
        rtc_ts_t ts;
        logic    late;
    } rtc_entry_t;
`else
    typedef struct packed {
        rtc_ts_t ts;
    } rtc_entry_t;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2
    } rtc_state_e;

    // Plain 62-bit magnitude compare; nsec >= 10^9 is not treated specially.
    function automatic logic ts_ge(input rtc_ts_t a, input rtc_ts_t b);
        return {a.sec, a.nsec} >= {b.sec, b.nsec};
    endfunction

endpackage

// File: rtl/rtc_sched_fifo.sv
// Register-based first-word-fall-through event queue with occupancy count.
module rtc_sched_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 62
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head_c,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH)) && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head_c  = mem[rd_ptr];

    // Storage needs no reset: an empty count makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rtc_trig_sched.sv
// Fires a fixed-width trigger pulse when the RTC reaches each queued event time, in FIFO order.
// Define RTC_SCHED_LATE_DROP_EN to drop events already late at acceptance and flag late_err.
module rtc_trig_sched
    import rtc_sched_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PULSE_CYCLES = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [SEC_W-1:0]       rtc_sec,
    input  logic [NSEC_W-1:0]      rtc_nsec,
    input  logic [SEC_W-1:0]       s_evt_sec,
    input  logic [NSEC_W-1:0]      s_evt_nsec,
    input  logic                   s_evt_valid,
    output logic                   s_evt_ready,
    input  logic                   flush,
    output logic                   trig_out,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   late_err,
    output logic                   busy
);

    localparam int unsigned CW         = $clog2(DEPTH) + 1;
    localparam logic [7:0]  PULSE_LAST = 8'(PULSE_CYCLES - 1);

    rtc_state_e state;
    rtc_state_e state_nxt;
    logic [7:0] pulse_cnt;
    logic [7:0] cnt_nxt;
    logic       trig_nxt;
    logic       push;
    logic       pop;
    logic       time_reached;
    rtc_ts_t    rtc_now;
    rtc_ts_t    evt_req;
    rtc_entry_t push_entry;
    rtc_entry_t head_entry;

    assign rtc_now      = '{sec: rtc_sec, nsec: rtc_nsec};
    assign evt_req      = '{sec: s_evt_sec, nsec: s_evt_nsec};
    assign s_evt_ready  = (evt_count != CW'(DEPTH)) && !flush;
    assign push         = s_evt_valid && s_evt_ready;
    assign time_reached = ts_ge(rtc_now, head_entry.ts);

    assign push_entry.ts = evt_req;
`ifdef RTC_SCHED_LATE_DROP_EN
    logic late_nxt;
    assign push_entry.late = ts_ge(rtc_now, evt_req);
`endif

    rtc_sched_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(rtc_entry_t))
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head_c    (head_entry),
        .count     (evt_count)
    );

    // Next state, pop strobe and registered-output next values.
    always_comb begin
        state_nxt = state;
        trig_nxt  = trig_out;
        cnt_nxt   = pulse_cnt;
        pop       = 1'b0;
`ifdef RTC_SCHED_LATE_DROP_EN
        late_nxt  = 1'b0;
`endif
        if (flush) begin
            state_nxt = ST_IDLE;
            trig_nxt  = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (evt_count != '0) begin
                        state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (evt_count == '0) begin
                        state_nxt = ST_IDLE;
                    end
`ifdef RTC_SCHED_LATE_DROP_EN
                    // Skip a cycle between drops so back-to-back late entries give distinct pulses.
                    else if (head_entry.late) begin
                        if (!late_err) begin
                            pop      = 1'b1;
                            late_nxt = 1'b1;
                        end
                    end
`endif
                    else if (time_reached) begin
                        pop       = 1'b1;
                        trig_nxt  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        trig_nxt  = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = (evt_count != '0) ? ST_WAIT : ST_IDLE;
                    end else begin
                        cnt_nxt = pulse_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    trig_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            trig_out  <= 1'b0;
            busy      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            state     <= state_nxt;
            trig_out  <= trig_nxt;
            busy      <= (state_nxt != ST_IDLE);
            pulse_cnt <= cnt_nxt;
        end
    end

`ifdef RTC_SCHED_LATE_DROP_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            late_err <= 1'b0;
        end else begin
            late_err <= late_nxt;
        end
    end
`else
    assign late_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_trig_sched.sv
// Randomized scoreboard bench for rtc_trig_sched against a queue-based behavioural model.
module tb_rtc_trig_sched;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned PULSE_CYCLES = 8;
`ifdef RTC_SCHED_LATE_DROP_EN
    localparam bit LATE_DROP = 1'b1;
`else
    localparam bit LATE_DROP = 1'b0;
`endif

    logic                   aclk = 1'b0;
    logic                   aresetn;
    logic [31:0]            rtc_sec;
    logic [29:0]            rtc_nsec;
    logic [31:0]            s_evt_sec;
    logic [29:0]            s_evt_nsec;
    logic                   s_evt_valid;
    logic                   s_evt_ready;
    logic                   flush;
    logic                   trig_out;
    logic [$clog2(DEPTH):0] evt_count;
    logic                   late_err;
    logic                   busy;

    always #5 aclk = ~aclk;

    rtc_trig_sched #(
        .DEPTH        (DEPTH),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .rtc_sec     (rtc_sec),
        .rtc_nsec    (rtc_nsec),
        .s_evt_sec   (s_evt_sec),
        .s_evt_nsec  (s_evt_nsec),
        .s_evt_valid (s_evt_valid),
        .s_evt_ready (s_evt_ready),
        .flush       (flush),
        .trig_out    (trig_out),
        .evt_count   (evt_count),
        .late_err    (late_err),
        .busy        (busy)
    );

    typedef struct {
        longint t;
        bit     late;
    } ment_t;

    typedef struct {
        int cyc;
        bit is_late;
    } sb_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    ment_t  mq[$];
    sb_t    sb[$];
    int     m_pulse = 0;
    bit     m_busy  = 1'b0;
    bit     m_late  = 1'b0;
    bit     last_push;
    longint now_t;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic longint ts(input int unsigned s, input int unsigned n);
        return longint'(s) * 64'd1073741824 + longint'(n);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, predict the next edge, then compare.
    task automatic step(input longint t_rtc, input bit v, input longint et, input bit fl);
        longint now;
        bit     rdy;
        bit     push;
        bit     do_pop;
        bit     nl;
        rtc_sec     = 32'(t_rtc >> 30);
        rtc_nsec    = 30'(t_rtc);
        s_evt_valid = v;
        s_evt_sec   = 32'(et >> 30);
        s_evt_nsec  = 30'(et);
        flush       = fl;
        #1;
        now  = t_rtc;
        rdy  = (mq.size() < DEPTH) && !fl;
        check("ready", s_evt_ready, rdy);
        push      = v && rdy;
        last_push = push;
        do_pop    = 1'b0;
        nl        = 1'b0;
        if (fl) begin
            mq.delete();
            m_pulse = 0;
            m_busy  = 1'b0;
        end else if (m_pulse > 0) begin
            m_pulse--;
            if (m_pulse == 0) m_busy = (mq.size() != 0);
        end else if (!m_busy) begin
            m_busy = (mq.size() != 0);
        end else if (mq.size() == 0) begin
            m_busy = 1'b0;
        end else if (LATE_DROP && mq[0].late) begin
            if (!m_late) begin
                do_pop = 1'b1;
                nl     = 1'b1;
                sb.push_back(sb_t'{cyc + 1, 1'b1});
            end
        end else if (now >= mq[0].t) begin
            do_pop  = 1'b1;
            m_pulse = PULSE_CYCLES;
            sb.push_back(sb_t'{cyc + 1, 1'b0});
        end
        m_late = nl;
        if (do_pop) void'(mq.pop_front());
        if (push) mq.push_back(ment_t'{et, et <= now});
        @(negedge aclk);
        check("evt_count", evt_count, mq.size());
        check("trig_out", trig_out, m_pulse > 0);
        check("busy", busy, m_busy);
        check("late_err", late_err, m_late);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(now_t, 1'b0, 0, 1'b0);
    endtask

    task automatic wait_model_pulse(input string name);
        int k;
        k = 0;
        while (m_pulse == 0 && k < 20) begin
            step(now_t, 1'b0, 0, 1'b0);
            k++;
        end
        check(name, m_pulse > 0, 1);
    endtask

    // Monitor: every trigger rise or late_err pulse must match the oldest expected event.
    initial begin : monitor
        logic prev;
        sb_t  it;
        prev = 1'b0;
        forever begin
            @(negedge aclk);
            if (aresetn === 1'b1 && ((trig_out === 1'b1 && !prev) || late_err === 1'b1)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected at cycle %0d: got trig=%0b late=%0b expected no event",
                             cyc, trig_out, late_err);
                end else begin
                    it = sb.pop_front();
                    check("sb_cycle", cyc, it.cyc);
                    check("sb_kind_late", late_err, it.is_late);
                end
            end
            prev = trig_out;
        end
    end

    initial begin : stim
        bit     pend;
        longint pend_t;
        int     n;
        int     rate;
        int     span;
        bit     fl;
        aresetn     = 1'b0;
        s_evt_valid = 1'b0;
        s_evt_sec   = '0;
        s_evt_nsec  = '0;
        flush       = 1'b0;
        rtc_sec     = '0;
        rtc_nsec    = '0;
        repeat (3) @(negedge aclk);
        check("rst_trig", trig_out, 0);
        check("rst_count", evt_count, 0);
        check("rst_busy", busy, 0);
        check("rst_late", late_err, 0);
        aresetn = 1'b1;

        // Single event reached exactly.
        now_t = ts(10, 0);
        step(now_t, 1'b1, ts(10, 500), 1'b0);
        for (int i = 0; i < 20; i++) begin
            now_t += 100;
            step(now_t, 1'b0, 0, 1'b0);
        end
        idle_steps(5);

        // Fill to DEPTH, hold the fifth request until a pop frees a slot.
        now_t = ts(20, 0);
        n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            step(now_t, 1'b1, ts(30, n), 1'b0);
            if (last_push) n++;
            if (i == 8) now_t = ts(31, 0);
        end
        check("fifth_accepted", n, 5);
        idle_steps(60);

        // Two events already overdue at acceptance.
        now_t = ts(6, 0);
        step(now_t, 1'b1, ts(5, 0), 1'b0);
        step(now_t, 1'b1, ts(5, 1), 1'b0);
        idle_steps(30);

        // Flush during the third pulse cycle with two entries still queued.
        now_t = ts(39, 0);
        for (int i = 0; i < 3; i++) step(now_t, 1'b1, ts(40, i), 1'b0);
        idle_steps(3);
        now_t = ts(40, 5);
        wait_model_pulse("flush_pulse_start");
        idle_steps(2);
        step(now_t, 1'b0, 0, 1'b1);
        check("flush_count", evt_count, 0);
        check("flush_trig", trig_out, 0);
        check("flush_busy", busy, 0);
        idle_steps(10);

        // Asynchronous reset mid-pulse.
        now_t = ts(49, 0);
        step(now_t, 1'b1, ts(50, 0), 1'b0);
        step(now_t, 1'b1, ts(50, 1), 1'b0);
        now_t = ts(50, 0);
        wait_model_pulse("rst_pulse_start");
        idle_steps(2);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_rst_trig", trig_out, 0);
        mq.delete();
        sb.delete();
        m_pulse     = 0;
        m_busy      = 1'b0;
        m_late      = 1'b0;
        s_evt_valid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        check("post_rst_count", evt_count, 0);
        check("post_rst_busy", busy, 0);
        idle_steps(5);

        // Randomized traffic; RTC nsec crosses 10^9 to exercise the literal compare.
        now_t  = ts(10, 999_999_000);
        pend   = 1'b0;
        pend_t = 0;
        for (int i = 0; i < 3000; i++) begin
            rate = (i < 1500) ? 5 : 1;
            span = (i < 1500) ? 80 : 400;
            now_t += longint'($urandom_range(0, 3));
            if (!pend && $urandom_range(0, rate) == 0) begin
                pend   = 1'b1;
                pend_t = now_t + longint'($urandom_range(0, span)) - 12;
            end
            fl = ($urandom_range(0, 199) == 0);
            step(now_t, pend, pend_t, fl);
            if (last_push) pend = 1'b0;
        end
        idle_steps(100);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
